// File: rtl/pc_fetch_sched.sv
// pc_fetch_sched: fetch-side scheduler. Owns the program counter, issues one outstanding
// instruction-memory request at a time and hands the returned instruction plus its PC
// to decode. Execute-stage redirects update the PC and squash any fetch in flight.
// A misaligned redirect target halts fetch with a sticky fault until reset.
//
// Ports:
//   i_clk, i_rst                    clock (rising edge), asynchronous active-high reset
//   i_redir_valid, i_redir_pc       single-cycle redirect request and target from execute
//   o_imem_req_valid/i_imem_req_ready, o_imem_addr
//                                   fetch request handshake and address
//   i_imem_rsp_valid, i_imem_rsp_data
//                                   fetch response (always accepted)
//   o_inst_valid/i_inst_ready, o_inst, o_inst_pc
//                                   instruction handshake towards decode
//   o_fault                         sticky misaligned-redirect fault
module pc_fetch_sched #(
    parameter int unsigned             CPU_WIDTH  = 64,
    parameter int unsigned             INST_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0]    RESET_PC   = CPU_WIDTH'(64'h8000_0000)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_redir_valid,
    input  logic [CPU_WIDTH-1:0]  i_redir_pc,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [CPU_WIDTH-1:0]  o_imem_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] i_imem_rsp_data,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0]  o_inst_pc,
    output logic                  o_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [CPU_WIDTH-1:0]    pc_q, pc_d;
    logic                    drop_q, drop_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [CPU_WIDTH-1:0]    inst_pc_q, inst_pc_d;
    logic                    fault_q, fault_d;

    logic redir_misaligned;

    assign redir_misaligned = i_redir_valid & (|i_redir_pc[1:0]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redir_misaligned) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else if (i_redir_valid) begin
                    pc_d = i_redir_pc;
                    // The request still leaves with the old pc; its response must be dropped.
                    if (i_imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (i_imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redir_misaligned) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else if (i_redir_valid) begin
                    pc_d = i_redir_pc;
                    if (i_imem_rsp_valid) begin
                        // Response for the stale pc is consumed here, nothing left in flight.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (i_imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = i_imem_rsp_data;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + CPU_WIDTH'(4);
                        state_d   = S_OUT;
                    end
                end
            end

            S_OUT: begin
                if (redir_misaligned) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else if (i_redir_valid) begin
                    pc_d    = i_redir_pc;
                    state_d = S_REQ;
                end else if (i_inst_ready) begin
                    state_d = S_REQ;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign o_imem_req_valid = (state_q == S_REQ);
    assign o_imem_addr      = pc_q;
    // A same-cycle redirect squashes the held instruction.
    assign o_inst_valid     = (state_q == S_OUT) & ~i_redir_valid;
    assign o_inst           = inst_q;
    assign o_inst_pc        = inst_pc_q;
    assign o_fault          = fault_q;

endmodule

// File: tb/tb_pc_fetch_sched.sv
// Testbench for pc_fetch_sched: directed stimulus with a scoreboard of expected fetch
// addresses and delivered instructions, checked by a separate negedge monitor.
module tb_pc_fetch_sched;

    localparam int unsigned CW = 64;
    localparam int unsigned IW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_redir_valid = 1'b0;
    logic [CW-1:0] i_redir_pc = '0;
    logic          o_imem_req_valid;
    logic          i_imem_req_ready = 1'b1;
    logic [CW-1:0] o_imem_addr;
    logic          i_imem_rsp_valid = 1'b0;
    logic [IW-1:0] i_imem_rsp_data = '0;
    logic          o_inst_valid;
    logic          i_inst_ready = 1'b1;
    logic [IW-1:0] o_inst;
    logic [CW-1:0] o_inst_pc;
    logic          o_fault;

    pc_fetch_sched #(
        .CPU_WIDTH  (CW),
        .INST_WIDTH (IW),
        .RESET_PC   (64'h8000_0000)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_redir_valid    (i_redir_valid),
        .i_redir_pc       (i_redir_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .o_fault          (o_fault)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    logic [CW-1:0] exp_addr_q[$];
    logic [CW-1:0] exp_ipc_q[$];
    logic [IW-1:0] exp_inst_q[$];

    // Instruction memory model: data = addr[31:0] + 0x13, response 'lat' cycles after
    // the earliest legal cycle.
    int            lat = 0;
    int            cnt = 0;
    bit            pending = 1'b0;
    logic [CW-1:0] paddr = '0;

    always @(negedge i_clk) begin
        i_imem_rsp_valid = 1'b0;
        if (i_rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (cnt == 0) begin
                    i_imem_rsp_valid = 1'b1;
                    i_imem_rsp_data  = paddr[31:0] + 32'h13;
                    pending          = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (o_imem_req_valid && i_imem_req_ready) begin
                pending = 1'b1;
                cnt     = lat;
                paddr   = o_imem_addr;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a handshake.
    always @(negedge i_clk) begin
        if (!i_rst && o_imem_req_valid && i_imem_req_ready) begin
            if (exp_addr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_req: got addr 0x%0h expected none at %0t",
                         o_imem_addr, $time);
            end else begin
                check("req_addr", o_imem_addr, exp_addr_q.pop_front());
            end
        end
        if (!i_rst && o_inst_valid && i_inst_ready) begin
            if (exp_ipc_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_inst: got pc 0x%0h inst 0x%0h expected none at %0t",
                         o_inst_pc, o_inst, $time);
            end else begin
                check("inst_pc", o_inst_pc, exp_ipc_q.pop_front());
                check("inst", 64'(o_inst), 64'(exp_inst_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_req(input logic [CW-1:0] a);
        int k;
        for (k = 0; k < 60; k++) begin
            if (o_imem_req_valid && o_imem_addr == a) break;
            step(1);
        end
        if (k == 60) check("wait_req_timeout", o_imem_addr, a);
    endtask

    task automatic wait_inst();
        int k;
        for (k = 0; k < 60; k++) begin
            if (o_inst_valid) break;
            step(1);
        end
        if (k == 60) check("wait_inst_timeout", 64'(o_inst_valid), 64'd1);
    endtask

    task automatic push_inst(input logic [CW-1:0] pc, input logic [IW-1:0] inst);
        exp_ipc_q.push_back(pc);
        exp_inst_q.push_back(inst);
    endtask

    task automatic do_reset(input logic req_rdy, input logic inst_rdy, input int l);
        i_rst            = 1'b1;
        i_redir_valid    = 1'b0;
        i_imem_req_ready = req_rdy;
        i_inst_ready     = inst_rdy;
        lat              = l;
        step(2);
        i_rst = 1'b0;
    endtask

    task automatic check_drained();
        check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        check("inst_q_empty", 64'(exp_ipc_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] pat;
        pat = 9'b010010010;  // bit 8 = cycle 1 after reset release

        // Reset values
        step(2);
        check("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
        check("rst_addr", o_imem_addr, 64'h8000_0000);
        check("rst_inst_valid", 64'(o_inst_valid), 64'd0);
        check("rst_inst", 64'(o_inst), 64'd0);
        check("rst_inst_pc", o_inst_pc, 64'd0);
        check("rst_fault", 64'(o_fault), 64'd0);

        // T1: zero-wait imem, always-ready decode, one fetch per 3 cycles
        exp_addr_q.push_back(64'h8000_0000);
        exp_addr_q.push_back(64'h8000_0004);
        exp_addr_q.push_back(64'h8000_0008);
        push_inst(64'h8000_0000, 32'h8000_0013);
        push_inst(64'h8000_0004, 32'h8000_0017);
        push_inst(64'h8000_0008, 32'h8000_001b);
        do_reset(1'b1, 1'b1, 0);
        for (int i = 0; i < 9; i++) begin
            check("t1_req_pattern", 64'(o_imem_req_valid), 64'(pat[8-i]));
            step(1);
        end
        i_imem_req_ready = 1'b0;
        step(3);
        check_drained();

        // T2: redirect in the same cycle as the handshake of 0x80000004
        exp_addr_q.push_back(64'h8000_0000);
        exp_addr_q.push_back(64'h8000_0004);
        exp_addr_q.push_back(64'h8000_1000);
        push_inst(64'h8000_0000, 32'h8000_0013);
        push_inst(64'h8000_1000, 32'h8000_1013);
        do_reset(1'b1, 1'b1, 0);
        wait_req(64'h8000_0004);
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_1000;
        step(1);
        i_redir_valid = 1'b0;
        wait_inst();
        i_imem_req_ready = 1'b0;
        step(3);
        check_drained();

        // T3: decode stall, then redirect plus ready squashes the held instruction
        exp_addr_q.push_back(64'h8000_0000);
        do_reset(1'b1, 1'b0, 0);
        wait_inst();
        for (int i = 0; i < 5; i++) begin
            check("t3_inst_hold", 64'(o_inst), 64'h8000_0013);
            check("t3_inst_pc_hold", o_inst_pc, 64'h8000_0000);
            check("t3_no_req", 64'(o_imem_req_valid), 64'd0);
            step(1);
        end
        exp_addr_q.push_back(64'h8000_2000);
        push_inst(64'h8000_2000, 32'h8000_2013);
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_2000;
        i_inst_ready  = 1'b1;
        #1;
        check("t3_squash", 64'(o_inst_valid), 64'd0);
        step(1);
        i_redir_valid = 1'b0;
        wait_inst();
        i_imem_req_ready = 1'b0;
        step(3);
        check_drained();

        // T4: misaligned redirect halts; async resets recover
        exp_addr_q.push_back(64'h8000_0000);
        do_reset(1'b1, 1'b1, 6);
        wait_req(64'h8000_0000);
        step(1);
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_0002;
        step(1);
        i_redir_valid = 1'b0;
        check("t4_fault", 64'(o_fault), 64'd1);
        check("t4_pc_kept", o_imem_addr, 64'h8000_0000);
        for (int i = 0; i < 10; i++) begin
            check("t4_halt_no_req", 64'(o_imem_req_valid), 64'd0);
            check("t4_halt_no_inst", 64'(o_inst_valid), 64'd0);
            step(1);
        end
        #2 i_rst = 1'b1;
        #1;
        check("t4_async_fault_clr", 64'(o_fault), 64'd0);
        exp_addr_q.push_back(64'h8000_0000);
        exp_addr_q.push_back(64'h8000_0004);
        push_inst(64'h8000_0000, 32'h8000_0013);
        do_reset(1'b1, 1'b1, 0);
        wait_inst();
        lat = 6;
        wait_req(64'h8000_0004);
        step(1);
        #2 i_rst = 1'b1;
        #1;
        check("t4_rst_req_valid", 64'(o_imem_req_valid), 64'd0);
        check("t4_rst_addr", o_imem_addr, 64'h8000_0000);
        check("t4_rst_inst_valid", 64'(o_inst_valid), 64'd0);
        check("t4_rst_inst", 64'(o_inst), 64'd0);
        check("t4_rst_inst_pc", o_inst_pc, 64'd0);
        check("t4_rst_fault", 64'(o_fault), 64'd0);
        exp_addr_q.push_back(64'h8000_0000);
        push_inst(64'h8000_0000, 32'h8000_0013);
        do_reset(1'b1, 1'b1, 0);
        wait_inst();
        i_imem_req_ready = 1'b0;
        step(3);
        check_drained();

        // T5: pc wraps from all-ones-minus-3 to zero without fault
        do_reset(1'b0, 1'b1, 0);
        wait_req(64'h8000_0000);
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1);
        i_redir_valid = 1'b0;
        check("t5_redir_addr", o_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        push_inst(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_000F);
        i_imem_req_ready = 1'b1;
        wait_inst();
        i_imem_req_ready = 1'b0;
        step(1);
        check("t5_wrap_req", 64'(o_imem_req_valid), 64'd1);
        check("t5_wrap_addr", o_imem_addr, 64'd0);
        check("t5_no_fault", 64'(o_fault), 64'd0);
        check_drained();

        // T6: redirect in WAIT with slow imem; late response dropped
        exp_addr_q.push_back(64'h8000_0000);
        do_reset(1'b1, 1'b1, 4);
        wait_req(64'h8000_0000);
        step(2);
        i_redir_valid = 1'b1;
        i_redir_pc    = 64'h8000_3000;
        step(1);
        i_redir_valid = 1'b0;
        exp_addr_q.push_back(64'h8000_3000);
        push_inst(64'h8000_3000, 32'h8000_3013);
        for (int i = 0; i < 2; i++) begin
            check("t6_wait_no_req", 64'(o_imem_req_valid), 64'd0);
            step(1);
        end
        wait_inst();
        i_imem_req_ready = 1'b0;
        step(3);
        check_drained();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sched.md
Name: pc_fetch_sched

Overview:
Fetch-side scheduler that owns the program counter and sequences instruction fetch. It issues one outstanding request at a time to instruction memory over a valid/ready handshake. It hands the returned instruction and its PC to decode over a second valid/ready handshake. Execute-stage redirects (taken branch, jal, jalr) update the PC, and any fetch still in flight is squashed.

Parameters:
CPU_WIDTH, 64, PC/address width
INST_WIDTH, 32, instruction width
RESET_PC, 64'h80000000, PC loaded at reset

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_redir_valid  input  1  redirect request from execute, single-cycle qualifier
i_redir_pc  input  CPU_WIDTH  redirect target
o_imem_req_valid  output  1  fetch request valid
i_imem_req_ready  input  1  imem accepts request
o_imem_addr  output  CPU_WIDTH  fetch address
i_imem_rsp_valid  input  1  fetch response valid (always accepted)
i_imem_rsp_data  input  INST_WIDTH  fetched instruction
o_inst_valid  output  1  instruction valid to decode
i_inst_ready  input  1  decode accepts instruction
o_inst  output  INST_WIDTH  held instruction
o_inst_pc  output  CPU_WIDTH  PC of held instruction
o_fault  output  1  sticky misaligned-redirect fault

Behaviour:
- Registered state: pc, state, drop, inst, inst_pc, fault.
- States: S_IDLE, S_REQ, S_WAIT, S_OUT, S_HALT.
- Reset (async assert, any state, including mid-transaction): pc=RESET_PC, state=S_IDLE, drop=0, inst=0, inst_pc=0, fault=0.
- Output values in reset: o_imem_req_valid=0, o_imem_addr=RESET_PC, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_fault=0.
- Imem responses arriving after reset for pre-reset requests are the memory's responsibility; none are expected.
- o_imem_req_valid = (state==S_REQ). o_imem_addr = pc.
- o_inst_valid = (state==S_OUT) & ~i_redir_valid. o_fault = fault.
- Redirect priority is above all other events in every state except S_IDLE and S_HALT, where it is ignored.
- Misaligned redirect: i_redir_valid with i_redir_pc[1:0]!=0 -> fault<=1, state<=S_HALT. pc is unchanged. drop state is irrelevant. This overrides the normal redirect action.
- S_IDLE: next cycle -> S_REQ. First request is asserted in the 2nd cycle after reset deassertion.
- S_REQ:
  - handshake (i_imem_req_ready), no redirect -> S_WAIT.
  - redirect, no handshake -> pc<=i_redir_pc, stay S_REQ. The address may change while valid; imem samples the address only on handshake.
  - redirect and handshake in the same cycle -> request goes out with old pc; pc<=i_redir_pc, drop<=1, -> S_WAIT.
- S_WAIT (response no earlier than the cycle after handshake):
  - i_imem_rsp_valid & drop -> discard, drop<=0, -> S_REQ.
  - i_imem_rsp_valid & ~drop & no redirect -> inst<=data, inst_pc<=pc, pc<=pc+4, -> S_OUT.
  - redirect with no response -> pc<=i_redir_pc, drop<=1, stay S_WAIT.
  - redirect with a non-dropped response in the same cycle -> discard response, pc<=i_redir_pc, drop<=0, -> S_REQ.
  - redirect with a dropped response in the same cycle -> discard, pc<=i_redir_pc, drop<=0, -> S_REQ.
- S_OUT: hold inst and inst_pc stable.
  - i_inst_ready & no redirect -> S_REQ.
  - redirect (with or without ready) -> instruction squashed (o_inst_valid low that cycle), pc<=i_redir_pc, -> S_REQ.
- S_HALT: no requests, o_inst_valid=0, all inputs ignored. Exit only via reset.
- Arithmetic: pc+4 is modulo 2^CPU_WIDTH; all-ones-minus-3 wraps to 0 without fault.
- Throughput: at most one outstanding request. Best case is one instruction per 3 cycles (REQ, WAIT, OUT) with zero-wait imem and always-ready decode.

Test Plan:
- Reset then zero-wait imem and always-ready decode -> addresses 0x80000000, 0x80000004, 0x80000008 issued every 3 cycles; o_inst_pc matches each; first o_imem_req_valid in the 2nd cycle after reset release.
- Redirect to 0x80001000 in the same cycle as handshake of 0x80000004 -> that response is discarded (no o_inst_valid); next request address is 0x80001000.
- Decode stalls 5 cycles in S_OUT -> o_inst and o_inst_pc stable, no new imem request; then redirect plus ready in the same cycle -> o_inst_valid=0 that cycle; next request is the target.
- Redirect to 0x80000002 -> o_fault=1, no further requests; async i_rst mid-S_WAIT -> all outputs return to reset values immediately, fetch restarts at 0x80000000.
- pc=0xFFFFFFFFFFFFFFFC fetched -> next request address is 0x0, no fault.
- Redirect in S_WAIT with a 4-cycle imem delay -> late response dropped; one request issued to the target after it.
